ewb_drain_arbiter: RTL

Memory-side arbiter and burst adapter between the L2 cache and physical memory. It serves L2 line-fill reads and drains the eviction write buffer (EWB) head entry as a write burst. Each transfer is a 256-bit line moved as four 64-bit beats. The EWB entry is popped only after its final write beat completes, so the line stays visible to EWB hit checks for the whole drain.

---
 rtl/ewb_drain_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ewb_drain_arbiter.sv
// ewb_drain_arbiter: memory-side arbiter between L2 line fills and EWB drains.
// Each 256-bit line moves as four 64-bit beats. The EWB head is popped only
// after its last write beat, so it stays visible to EWB hit checks while draining.
module ewb_drain_arbiter #(
    parameter int unsigned width      = 256,
    parameter int unsigned beat_width = 64,
    parameter int unsigned starve_max = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ewb_empty_i,
    input  logic                  ewb_full_i,
    input  logic [width-1:0]      ewb_data_i,
    input  logic [31:0]           ewb_addr_i,
    output logic                  ewb_yumi_o,
    output logic                  draining_o,
    output logic [31:0]           drain_addr_o,
    input  logic                  rd_req_i,
    input  logic [31:0]           rd_addr_i,
    output logic [width-1:0]      rd_data_o,
    output logic                  rd_resp_o,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [beat_width-1:0] mem_wdata_o,
    input  logic [beat_width-1:0] mem_rdata_i,
    input  logic                  mem_resp_i
);

    localparam int unsigned beats     = width / beat_width;
    localparam int unsigned cnt_w     = (beats > 1) ? $clog2(beats) : 1;
    localparam int unsigned starve_w  = $clog2(starve_max + 1);
    localparam logic [cnt_w-1:0]    last_beat  = cnt_w'(beats - 1);
    localparam logic [starve_w-1:0] starve_lim = starve_w'(starve_max);
    localparam logic [31:0]         line_mask  = ~32'(width / 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [cnt_w-1:0]    cnt_q, cnt_d;
    logic [starve_w-1:0] starve_q, starve_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         drain_addr_q, drain_addr_d;
    logic [width-1:0]    wbuf_q, wbuf_d;
    logic [width-1:0]    rdata_q, rdata_d;
    logic                wr_grant;
    logic                rd_grant;

    // State and datapath registers; reset aborts any burst without pop or resp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            starve_q     <= '0;
            addr_q       <= '0;
            drain_addr_q <= '0;
            wbuf_q       <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
            addr_q       <= addr_d;
            drain_addr_q <= drain_addr_d;
            wbuf_q       <= wbuf_d;
            rdata_q      <= rdata_d;
        end
    end

    // Grant arbitration, beat sequencing and read-line assembly.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        starve_d     = starve_q;
        addr_d       = addr_q;
        drain_addr_d = drain_addr_q;
        wbuf_d       = wbuf_q;
        rdata_d      = rdata_q;
        wr_grant     = 1'b0;
        rd_grant     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A full or starved EWB beats reads; otherwise reads win.
                if (!ewb_empty_i && (ewb_full_i || starve_q == starve_lim)) begin
                    wr_grant = 1'b1;
                end else if (rd_req_i) begin
                    rd_grant = 1'b1;
                end else if (!ewb_empty_i) begin
                    wr_grant = 1'b1;
                end

                if (wr_grant) begin
                    addr_d       = ewb_addr_i & line_mask;
                    drain_addr_d = ewb_addr_i & line_mask;
                    wbuf_d       = ewb_data_i;
                    cnt_d        = '0;
                    state_d      = WR_BURST;
                end else if (rd_grant) begin
                    addr_d  = rd_addr_i & line_mask;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end
            end
            WR_BURST: begin
                if (mem_resp_i) begin
                    cnt_d = cnt_q + cnt_w'(1);
                    if (cnt_q == last_beat) begin
                        state_d = WR_DONE;
                    end
                end
            end
            RD_BURST: begin
                if (mem_resp_i) begin
                    for (int b = 0; b < int'(beats); b++) begin
                        if (cnt_q == cnt_w'(b)) begin
                            rdata_d[b*beat_width +: beat_width] = mem_rdata_i;
                        end
                    end
                    cnt_d = cnt_q + cnt_w'(1);
                    if (cnt_q == last_beat) begin
                        state_d = RD_DONE;
                    end
                end
            end
            WR_DONE: state_d = IDLE;
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Count reads that overtook a waiting EWB entry.
        if (ewb_empty_i || wr_grant) begin
            starve_d = '0;
        end else if (rd_grant && starve_q != starve_lim) begin
            starve_d = starve_q + starve_w'(1);
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        ewb_yumi_o   = (state_q == WR_DONE);
        rd_resp_o    = (state_q == RD_DONE);
        mem_read_o   = (state_q == RD_BURST);
        mem_write_o  = (state_q == WR_BURST);
        draining_o   = (state_q == WR_BURST) || (state_q == WR_DONE);
        drain_addr_o = drain_addr_q;
        mem_addr_o   = addr_q;
        rd_data_o    = rdata_q;
        mem_wdata_o  = '0;
        if (state_q == WR_BURST) begin
            for (int b = 0; b < int'(beats); b++) begin
                if (cnt_q == cnt_w'(b)) begin
                    mem_wdata_o = wbuf_q[b*beat_width +: beat_width];
                end
            end
        end
    end

endmodule
